// File: rtl/silife_max7219_rx.sv
// silife_max7219_rx: SPI receiver that models a daisy chain of MAX7219 LED
// drivers (the far end of the silife MAX7219 output). Each load transaction
// of NUM_DEVICES*16 bits is decoded into per-device digit rows and control
// registers. The results are exposed through a registered random-access read port.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   i_cs, i_sck, i_mosi asynchronous SPI inputs (CS active low, SCK rising)
//   i_rd_device/digit   read address; o_rd_* valid one cycle later
//   o_rd_data           digit byte; o_rd_intensity/scan_limit/decode/
//                       shutdown_n/test: control registers of i_rd_device
//   o_frame_strobe      one-cycle pulse per committed transaction
//   o_frame_count       committed transactions (wrapping)
//   o_err_count         rejected transactions (saturating)
//   o_busy              transaction in progress
module silife_max7219_rx #(
  parameter int unsigned NUM_DEVICES = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_cs,
  input  logic                           i_sck,
  input  logic                           i_mosi,
  input  logic [$clog2(NUM_DEVICES)-1:0] i_rd_device,
  input  logic [2:0]                     i_rd_digit,
  output logic [7:0]                     o_rd_data,
  output logic [3:0]                     o_rd_intensity,
  output logic [2:0]                     o_rd_scan_limit,
  output logic [7:0]                     o_rd_decode,
  output logic                           o_rd_shutdown_n,
  output logic                           o_rd_test,
  output logic                           o_frame_strobe,
  output logic [15:0]                    o_frame_count,
  output logic [7:0]                     o_err_count,
  output logic                           o_busy
);

  localparam int unsigned DEV_W = $clog2(NUM_DEVICES);
  localparam int unsigned SR_W  = NUM_DEVICES * 16;
  // The top 4 bits of the first word are don't-care and simply fall off the end.
  localparam int unsigned SH_W  = SR_W - 4;
  localparam int unsigned CNT_W = $clog2(SR_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SR_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SR_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   armed_q, armed_d;
  logic [SH_W-1:0]        shift_q, shift_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   strobe_q, strobe_d;
  logic [15:0]            frame_q, frame_d;
  logic [7:0]             err_q, err_d;

  logic [7:0] digit_q [NUM_DEVICES][8];
  logic [7:0] digit_d [NUM_DEVICES][8];
  logic [7:0] decode_q [NUM_DEVICES];
  logic [7:0] decode_d [NUM_DEVICES];
  logic [3:0] inten_q [NUM_DEVICES];
  logic [3:0] inten_d [NUM_DEVICES];
  logic [2:0] scan_q [NUM_DEVICES];
  logic [2:0] scan_d [NUM_DEVICES];
  logic       shdn_q [NUM_DEVICES];
  logic       shdn_d [NUM_DEVICES];
  logic       test_q [NUM_DEVICES];
  logic       test_d [NUM_DEVICES];

  logic [7:0] rd_data_q, rd_data_d, rd_decode_q, rd_decode_d;
  logic [3:0] rd_inten_q, rd_inten_d;
  logic [2:0] rd_scan_q, rd_scan_d;
  logic       rd_shdn_q, rd_shdn_d, rd_test_q, rd_test_d;

  logic cs_s, sck_s, mosi_s, sck_rise, commit, rd_valid;
  logic [3:0] addr;
  logic [7:0] data;

  generate
    if (NUM_DEVICES == (1 << DEV_W)) begin : g_rd_full
      assign rd_valid = 1'b1;
    end else begin : g_rd_part
      assign rd_valid = (32'(i_rd_device) < NUM_DEVICES);
    end
  endgenerate

  always_comb begin
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], i_cs};
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], i_sck};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], i_mosi};
    cs_s        = cs_sync_q[SYNC_STAGES-1];
    sck_s       = sck_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    sck_prev_d  = sck_s;
    sck_rise    = sck_s & ~sck_prev_q;

    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    strobe_d = 1'b0;
    frame_d  = frame_q;
    err_d    = err_q;
    commit   = 1'b0;
    // A new transaction may only start after CS has been seen high, so a
    // transaction already in flight when reset is released is skipped.
    armed_d  = armed_q | cs_s;

    case (state_q)
      S_IDLE: begin
        // Level test on an armed flag: a CS fall during LATCH is still taken here.
        if (!cs_s && armed_q) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          busy_d  = 1'b1;
          armed_d = 1'b0;
        end
      end
      S_SHIFT: begin
        // CS release has priority; a coincident SCK edge is dropped.
        if (cs_s) begin
          state_d = S_LATCH;
          busy_d  = 1'b0;
        end else if (sck_rise) begin
          shift_d = {shift_q[SH_W-2:0], mosi_s};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LATCH: begin
        state_d = S_IDLE;
        if (cnt_q == CNT_FULL) begin
          commit   = 1'b1;
          strobe_d = 1'b1;
          frame_d  = frame_q + 16'd1;
        end else if (cnt_q != '0) begin
          if (err_q != '1) err_d = err_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    digit_d  = digit_q;
    decode_d = decode_q;
    inten_d  = inten_q;
    scan_d   = scan_q;
    shdn_d   = shdn_q;
    test_d   = test_q;
    addr     = '0;
    data     = '0;
    if (commit) begin
      // Device d holds the word that was shifted in (NUM_DEVICES-1-d) words
      // ago, i.e. bits [d*16 +: 16] of the shift register.
      for (int unsigned d = 0; d < NUM_DEVICES; d++) begin
        addr = shift_q[d*16+8 +: 4];
        data = shift_q[d*16 +: 8];
        case (addr)
          4'h1, 4'h2, 4'h3, 4'h4,
          4'h5, 4'h6, 4'h7, 4'h8: digit_d[d][addr[2:0] - 3'd1] = data;
          4'h9: decode_d[d] = data;
          4'hA: inten_d[d]  = data[3:0];
          4'hB: scan_d[d]   = data[2:0];
          4'hC: shdn_d[d]   = data[0];
          4'hF: test_d[d]   = data[0];
          default: ;
        endcase
      end
    end

    // Read from next-state values so a commit is visible on the next cycle.
    rd_data_d   = '0;
    rd_decode_d = '0;
    rd_inten_d  = '0;
    rd_scan_d   = '0;
    rd_shdn_d   = 1'b0;
    rd_test_d   = 1'b0;
    if (rd_valid) begin
      rd_data_d   = digit_d[i_rd_device][i_rd_digit];
      rd_decode_d = decode_d[i_rd_device];
      rd_inten_d  = inten_d[i_rd_device];
      rd_scan_d   = scan_d[i_rd_device];
      rd_shdn_d   = shdn_d[i_rd_device];
      rd_test_d   = test_d[i_rd_device];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cs_sync_q   <= '0;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      armed_q     <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      strobe_q    <= 1'b0;
      frame_q     <= '0;
      err_q       <= '0;
      for (int unsigned d = 0; d < NUM_DEVICES; d++) begin
        for (int unsigned r = 0; r < 8; r++) digit_q[d][r] <= '0;
        decode_q[d] <= '0;
        inten_q[d]  <= '0;
        scan_q[d]   <= '0;
        shdn_q[d]   <= 1'b0;
        test_q[d]   <= 1'b0;
      end
      rd_data_q   <= '0;
      rd_decode_q <= '0;
      rd_inten_q  <= '0;
      rd_scan_q   <= '0;
      rd_shdn_q   <= 1'b0;
      rd_test_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_sync_q   <= cs_sync_d;
      sck_sync_q  <= sck_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_prev_d;
      armed_q     <= armed_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      strobe_q    <= strobe_d;
      frame_q     <= frame_d;
      err_q       <= err_d;
      digit_q     <= digit_d;
      decode_q    <= decode_d;
      inten_q     <= inten_d;
      scan_q      <= scan_d;
      shdn_q      <= shdn_d;
      test_q      <= test_d;
      rd_data_q   <= rd_data_d;
      rd_decode_q <= rd_decode_d;
      rd_inten_q  <= rd_inten_d;
      rd_scan_q   <= rd_scan_d;
      rd_shdn_q   <= rd_shdn_d;
      rd_test_q   <= rd_test_d;
    end
  end

  assign o_rd_data       = rd_data_q;
  assign o_rd_intensity  = rd_inten_q;
  assign o_rd_scan_limit = rd_scan_q;
  assign o_rd_decode     = rd_decode_q;
  assign o_rd_shutdown_n = rd_shdn_q;
  assign o_rd_test       = rd_test_q;
  assign o_frame_strobe  = strobe_q;
  assign o_frame_count   = frame_q;
  assign o_err_count     = err_q;
  assign o_busy          = busy_q;

endmodule

// File: tb/tb_silife_max7219_rx.sv
// Testbench for silife_max7219_rx: drives SPI transactions (directed and
// random) and compares the read port and counters against a register-level
// model of a MAX7219 chain.
module tb_silife_max7219_rx;

  localparam int unsigned ND   = 16;
  localparam int unsigned HALF = 3;  // SCK half period in clk cycles

  logic        clk = 1'b0;
  logic        reset, i_cs, i_sck, i_mosi;
  logic [3:0]  i_rd_device;
  logic [2:0]  i_rd_digit;
  logic [7:0]  o_rd_data, o_rd_decode, o_err_count;
  logic [3:0]  o_rd_intensity;
  logic [2:0]  o_rd_scan_limit;
  logic        o_rd_shutdown_n, o_rd_test, o_frame_strobe, o_busy;
  logic [15:0] o_frame_count;

  silife_max7219_rx #(.NUM_DEVICES(ND), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .i_cs(i_cs), .i_sck(i_sck), .i_mosi(i_mosi),
    .i_rd_device(i_rd_device), .i_rd_digit(i_rd_digit),
    .o_rd_data(o_rd_data), .o_rd_intensity(o_rd_intensity),
    .o_rd_scan_limit(o_rd_scan_limit), .o_rd_decode(o_rd_decode),
    .o_rd_shutdown_n(o_rd_shutdown_n), .o_rd_test(o_rd_test),
    .o_frame_strobe(o_frame_strobe), .o_frame_count(o_frame_count),
    .o_err_count(o_err_count), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int strobe_cnt = 0;

  always @(posedge clk) begin
    if (reset) strobe_cnt <= 0;
    else if (o_frame_strobe) strobe_cnt <= strobe_cnt + 1;
  end

  // Reference model of the device chain.
  logic [7:0]  m_digit [ND][8];
  logic [7:0]  m_decode [ND];
  logic [3:0]  m_int [ND];
  logic [2:0]  m_scan [ND];
  logic        m_shdn [ND];
  logic        m_test [ND];
  int          m_frames, m_errs;
  logic [15:0] tx_words [ND];
  logic [31:0] grid [32];
  logic [31:0] rebuilt [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      for (int r = 0; r < 8; r++) m_digit[d][r] = 8'h00;
      m_decode[d] = 8'h00; m_int[d] = 4'h0; m_scan[d] = 3'h0;
      m_shdn[d] = 1'b0; m_test[d] = 1'b0;
    end
    m_frames = 0;
    m_errs = 0;
  endtask

  task automatic model_commit();
    int a;
    logic [7:0] v;
    for (int k = 0; k < ND; k++) begin
      a = int'(tx_words[k][11:8]);
      v = tx_words[k][7:0];
      if (a >= 1 && a <= 8) m_digit[ND-1-k][a-1] = v;
      else if (a == 9)  m_decode[ND-1-k] = v;
      else if (a == 10) m_int[ND-1-k] = v[3:0];
      else if (a == 11) m_scan[ND-1-k] = v[2:0];
      else if (a == 12) m_shdn[ND-1-k] = v[0];
      else if (a == 15) m_test[ND-1-k] = v[0];
    end
  endtask

  task automatic send_bit(input logic b);
    i_mosi = b;
    repeat (HALF) @(negedge clk);
    i_sck = 1'b1;
    repeat (HALF) @(negedge clk);
    i_sck = 1'b0;
  endtask

  // One CS-framed transaction of nbits; bits come from tx_words or are random.
  task automatic spi_xfer(input int nbits, input bit use_words, input bit do_checks);
    logic b;
    @(negedge clk);
    i_cs = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      b = use_words ? tx_words[i/16][15-(i%16)] : 1'($urandom);
      send_bit(b);
      if (i == 0 && do_checks) chk("busy_in_xfer", 32'(o_busy), 32'd1);
    end
    repeat (HALF) @(negedge clk);
    i_cs = 1'b1;
    repeat (6) @(negedge clk);
    if (nbits == ND*16) begin
      model_commit();
      m_frames = (m_frames + 1) % 65536;
    end else if (nbits != 0 && m_errs < 255) begin
      m_errs++;
    end
    if (do_checks) begin
      chk("frame_count", 32'(o_frame_count), 32'(m_frames));
      chk("err_count", 32'(o_err_count), 32'(m_errs));
      chk("strobes", 32'(strobe_cnt), 32'(m_frames));
      chk("busy_after", 32'(o_busy), 32'd0);
    end
  endtask

  task automatic check_regs();
    for (int d = 0; d < ND; d++) begin
      for (int r = 0; r < 8; r++) begin
        @(negedge clk);
        i_rd_device = 4'(d);
        i_rd_digit = 3'(r);
        @(negedge clk);
        chk($sformatf("digit d%0d r%0d", d, r), 32'(o_rd_data), 32'(m_digit[d][r]));
        if (r == 0) begin
          chk($sformatf("decode d%0d", d), 32'(o_rd_decode), 32'(m_decode[d]));
          chk($sformatf("intensity d%0d", d), 32'(o_rd_intensity), 32'(m_int[d]));
          chk($sformatf("scan d%0d", d), 32'(o_rd_scan_limit), 32'(m_scan[d]));
          chk($sformatf("shutdown_n d%0d", d), 32'(o_rd_shutdown_n), 32'(m_shdn[d]));
          chk($sformatf("test d%0d", d), 32'(o_rd_test), 32'(m_test[d]));
        end
      end
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] y;
    for (int i = 0; i < 8; i++) y[i] = x[7-i];
    return y;
  endfunction

  // Chain position of 8x8 tile (tr, tc); odd tile rows reversed when serpentine.
  function automatic int dev_of(input int tr, input int tc, input bit serp);
    int c;
    c = (serp && tr[0]) ? 3 - tc : tc;
    return tr*4 + c;
  endfunction

  task automatic glider_test(input bit serp, input bit revc);
    int ox, oy, dv;
    logic [7:0] byt;
    for (int y = 0; y < 32; y++) grid[y] = 32'h0;
    ox = int'($urandom_range(0, 29));
    oy = int'($urandom_range(0, 29));
    grid[oy][31-(ox+1)]   = 1'b1;
    grid[oy+1][31-(ox+2)] = 1'b1;
    grid[oy+2][31-ox]     = 1'b1;
    grid[oy+2][31-(ox+1)] = 1'b1;
    grid[oy+2][31-(ox+2)] = 1'b1;
    for (int r = 0; r < 8; r++) begin
      for (int tr = 0; tr < 4; tr++) begin
        for (int tc = 0; tc < 4; tc++) begin
          byt = grid[tr*8+r][31-tc*8 -: 8];
          if (revc) byt = rev8(byt);
          dv = dev_of(tr, tc, serp);
          tx_words[ND-1-dv] = {4'h0, 4'(r+1), byt};
        end
      end
      spi_xfer(ND*16, 1'b1, 1'b0);
    end
    for (int tr = 0; tr < 4; tr++) begin
      for (int tc = 0; tc < 4; tc++) begin
        for (int r = 0; r < 8; r++) begin
          @(negedge clk);
          i_rd_device = 4'(dev_of(tr, tc, serp));
          i_rd_digit = 3'(r);
          @(negedge clk);
          byt = revc ? rev8(o_rd_data) : o_rd_data;
          rebuilt[tr*8+r][31-tc*8 -: 8] = byt;
        end
      end
    end
    for (int y = 0; y < 32; y++)
      chk($sformatf("glider s%0d r%0d row%0d", serp, revc, y), rebuilt[y], grid[y]);
    chk("glider_intensity", 32'(o_rd_intensity), 32'hF);
  endtask

  initial begin
    reset = 1'b1; i_cs = 1'b1; i_sck = 1'b0; i_mosi = 1'b0;
    i_rd_device = 4'd3; i_rd_digit = 3'd5;
    model_reset();
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_data", 32'(o_rd_data), 32'h0);
    chk("reset_intensity", 32'(o_rd_intensity), 32'h0);
    chk("reset_shutdown_n", 32'(o_rd_shutdown_n), 32'h0);
    chk("reset_frames", 32'(o_frame_count), 32'h0);
    chk("reset_errs", 32'(o_err_count), 32'h0);
    chk("reset_busy", 32'(o_busy), 32'h0);

    // Shutdown off, then intensity 7 on every device.
    for (int k = 0; k < ND; k++) tx_words[k] = 16'h0C01;
    spi_xfer(ND*16, 1'b1, 1'b1);
    for (int k = 0; k < ND; k++) tx_words[k] = 16'h0A07;
    spi_xfer(ND*16, 1'b1, 1'b1);
    chk("two_strobes", 32'(strobe_cnt), 32'd2);
    check_regs();

    // First word lands on the last device.
    for (int k = 0; k < ND; k++) tx_words[k] = 16'h0000;
    tx_words[0] = 16'h03A5;
    spi_xfer(ND*16, 1'b1, 1'b1);
    check_regs();

    // Random words, including no-op and ignored addresses.
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < ND; k++) tx_words[k] = 16'($urandom);
      spi_xfer(ND*16, 1'b1, 1'b1);
      check_regs();
    end

    // Bad lengths leave registers alone.
    spi_xfer(ND*16 - 1, 1'b0, 1'b1);
    spi_xfer(ND*16 + 1, 1'b0, 1'b1);
    check_regs();
    for (int n = 0; n < 300; n++) spi_xfer(1, 1'b0, 1'b0);
    chk("err_saturated", 32'(o_err_count), 32'hFF);
    chk("frames_after_errs", 32'(o_frame_count), 32'(m_frames));

    // Reset in the middle of a transaction; CS still low at release.
    @(negedge clk);
    i_cs = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 100; i++) send_bit(1'($urandom));
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    chk("midreset_frames", 32'(o_frame_count), 32'h0);
    chk("midreset_errs", 32'(o_err_count), 32'h0);
    for (int i = 0; i < 20; i++) send_bit(1'($urandom));
    chk("midreset_not_busy", 32'(o_busy), 32'h0);
    i_cs = 1'b1;
    repeat (6) @(negedge clk);
    chk("midreset_no_err", 32'(o_err_count), 32'h0);
    for (int k = 0; k < ND; k++) tx_words[k] = 16'($urandom);
    spi_xfer(ND*16, 1'b1, 1'b1);
    chk("midreset_one_frame", 32'(o_frame_count), 32'd1);
    check_regs();

    // Full-brightness glider image under two tile/column orderings.
    for (int k = 0; k < ND; k++) tx_words[k] = 16'h0A0F;
    spi_xfer(ND*16, 1'b1, 1'b1);
    glider_test(1'b0, 1'b0);
    glider_test(1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/silife_max7219_rx.md
Name: silife_max7219_rx

Overview:
- SPI receiver that emulates a daisy chain of MAX7219 LED drivers, i.e. the far end of the silife MAX7219 SPI output (spi_cs / spi_sck / spi_mosi).
- Decodes each load transaction into per-device digit rows and control registers, and exposes them through a random-access read port plus frame and error counters.
- Used as a display model in chip-level benches, and in FPGA builds to mirror the LED matrix contents onto another display.

Parameters:
- NUM_DEVICES, 16, MAX7219 devices in the chain (4x4 matrices of 8x8 cover a 32x32 grid).
- SYNC_STAGES, 2, synchronizer flops on i_cs / i_sck / i_mosi (minimum 2).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- i_cs  input  1  SPI LOAD/CS, active low; asynchronous to clk
- i_sck  input  1  SPI clock; data sampled on rising edge; asynchronous to clk
- i_mosi  input  1  SPI data, MSB first; asynchronous to clk
- i_rd_device  input  $clog2(NUM_DEVICES)  device index for the read port
- i_rd_digit  input  3  digit/row index 0..7 (register address 1..8) for the read port
- o_rd_data  output  8  stored digit byte
- o_rd_intensity  output  4  intensity register of i_rd_device
- o_rd_scan_limit  output  3  scan-limit register of i_rd_device
- o_rd_decode  output  8  decode-mode register of i_rd_device
- o_rd_shutdown_n  output  1  shutdown register bit 0 of i_rd_device (0 = shutdown)
- o_rd_test  output  1  display-test register bit 0 of i_rd_device
- o_frame_strobe  output  1  one-cycle pulse per committed transaction
- o_frame_count  output  16  committed transactions, wraps at 0xFFFF -> 0
- o_err_count  output  8  rejected transactions, saturates at 0xFF
- o_busy  output  1  high while the synchronized CS is low

Behaviour:
- Synchronization:
  - i_cs, i_sck and i_mosi each pass through SYNC_STAGES flops; edges are detected on the synchronized values.
  - Source requirement: SCK high time and SCK low time each at least SYNC_STAGES+1 clk; MOSI stable for SYNC_STAGES+1 clk around each SCK rise.
- States: IDLE, SHIFT, LATCH.
  - IDLE: synchronized CS falling -> SHIFT; clear bit counter; o_busy=1.
  - SHIFT: on each synchronized SCK rising edge, shift MOSI into the LSB of a NUM_DEVICES*16-bit shift register; bit counter increments, saturating at NUM_DEVICES*16+1. SCK edges while CS is high are ignored.
  - SHIFT -> LATCH on synchronized CS rising; o_busy=0.
  - LATCH (one cycle), then -> IDLE:
    - bit count == NUM_DEVICES*16: commit, pulse o_frame_strobe, o_frame_count+1.
    - bit count == 0: ignore silently; no strobe, no error.
    - any other count: discard the transaction, o_err_count+1 (saturating); no register changes.
- Word mapping:
  - Word k (0 = first 16 bits shifted in) belongs to device NUM_DEVICES-1-k; device 0 receives the last word.
  - Each word: bits [15:12] are ignored; [11:8] are the register address; [7:0] are the data.
- Commit decode, per device, all devices in parallel in the LATCH cycle:
  - Address 0: no-op.
  - Addresses 1..8: digit[addr-1] <= data.
  - 0x9: decode <= data. 0xA: intensity <= data[3:0]. 0xB: scan_limit <= data[2:0]. 0xC: shutdown_n <= data[0]. 0xF: test <= data[0].
  - Addresses 0xD and 0xE: ignored.
- Read port:
  - Registered, 1-cycle latency from i_rd_device / i_rd_digit to all o_rd_* outputs.
  - A read of a cell written in the LATCH cycle returns the new value in the following cycle.
  - i_rd_device >= NUM_DEVICES returns 0 on all o_rd_* outputs.
- Reset (overrides everything, including a mid-transaction reset): state IDLE; shift register and bit counter cleared; all digits, decode, intensity, scan_limit, shutdown_n and test = 0 (MAX7219 power-up); counters = 0; o_frame_strobe = 0; o_busy = 0; o_rd_* = 0.
- Transaction in flight at reset release: if the synchronized CS is already low, it is not captured; the block waits for a CS high before the next fall.
- Simultaneous events:
  - A CS rising edge detected in the same cycle as an SCK rising edge: the SCK edge is dropped and the bit count is checked without it.
  - A new CS fall in the LATCH cycle is seen in IDLE on the next cycle; with SYNC_STAGES >= 2 no fall is lost.

Test Plan:
- Reset, then read device 3 digit 5 -> o_rd_data=0x00, o_rd_intensity=0, o_rd_shutdown_n=0, o_frame_count=0, o_err_count=0.
- One 256-bit transaction, all words 0x0C01, then one with all words 0x0A07 -> every device shutdown_n=1, intensity=7; exactly 2 strobes; o_frame_count=2.
- Transaction where word 0 is 0x03A5 and the other words are 0x0000 -> device 15 digit 2 = 0xA5; all other digits remain 0x00.
- Transaction of 255 bits, then one of 257 bits -> no register changes, o_err_count=2, o_frame_count unchanged; 300 short transactions -> o_err_count=0xFF.
- Reset asserted after 100 bits of a transaction, then a full 256-bit transaction -> only the second transaction commits; o_frame_count=1.
- Loopback from silife_max7219 with a glider pattern in the grid -> the 32x32 image rebuilt from o_rd_data matches the grid rows for the serpentine and reverse-column settings; o_rd_intensity=0xF.
